// File: rtl/down_timer.sv
// Loadable down-counter timer with an IDLE/RUN/DONE FSM and a one-cycle done pulse.
// Optional macro AUTO_RELOAD_EN: leaving DONE restarts from the reload register when it is non-zero.
module down_timer #(
   parameter int WIDTH = 3
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      if (load) begin
         // A load overrides enable and any terminal transition in the same cycle.
         cnt_d    = load_val;
         reload_d = load_val;
         state_d  = (load_val != CNT_ZERO) ? S_RUN : S_DONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_RUN: begin
               if (en) begin
                  // Terminal at 1 (0 treated the same) so the count never wraps.
                  if (cnt_q == CNT_ONE || cnt_q == CNT_ZERO) begin
                     cnt_d   = CNT_ZERO;
                     state_d = S_DONE;
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
            end
            S_DONE: begin
`ifdef AUTO_RELOAD_EN
               if (reload_q != CNT_ZERO) begin
                  cnt_d   = reload_q;
                  state_d = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
`else
               state_d = S_IDLE;
`endif
            end
            default: begin
               cnt_d   = CNT_ZERO;
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= CNT_ZERO;
         reload_q <= CNT_ZERO;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifndef AUTO_RELOAD_EN
   // Reload value is only consumed by the auto-reload build.
   logic reload_unused;
   assign reload_unused = ^reload_q;
`endif

   assign Q    = cnt_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed scoreboard bench for down_timer; expectations are queued at drive time and checked one edge later.
module tb_down_timer;

   localparam int W = 3;
`ifdef AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [W-1:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   logic         CLK = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         en;
   logic [W-1:0] Q;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   down_timer #(.WIDTH(W)) dut (
      .CLK      (CLK),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .Q        (Q),
      .busy     (busy),
      .done     (done)
   );

   always #5 CLK = ~CLK;

   task automatic check_now(input string tag, input logic [W-1:0] eq, input logic eb, input logic ed);
      checks++;
      assert (Q === eq) else begin
         errors++;
         $error("FAIL %s.Q got %0d expected %0d", tag, Q, eq);
      end
      checks++;
      assert (busy === eb) else begin
         errors++;
         $error("FAIL %s.busy got %0b expected %0b", tag, busy, eb);
      end
      checks++;
      assert (done === ed) else begin
         errors++;
         $error("FAIL %s.done got %0b expected %0b", tag, done, ed);
      end
   endtask

   // Drive one cycle of inputs, queue its expected outcome, then compare after the edge.
   task automatic step(input string tag, input logic ld, input logic [W-1:0] lv, input logic e,
                       input logic [W-1:0] eq, input logic eb, input logic ed);
      exp_t x;
      load     = ld;
      load_val = lv;
      en       = e;
      x.tag = tag; x.q = eq; x.busy = eb; x.done = ed;
      sb.push_back(x);
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s.scoreboard got empty expected entry", tag);
      end else begin
         x = sb.pop_front();
         check_now(x.tag, x.q, x.busy, x.done);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      check_now(tag, 3'd0, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
      #1;
      check_now("reset_init", 3'd0, 1'b0, 1'b0);
      step("reset_ignores_load", 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Load 3 with en held: 3,2,1,0 with done on the zero cycle.
      step("ld3",   1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0);
      step("ld3_2", 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0);
      step("ld3_1", 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
      step("ld3_0", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
      step("ld3_after", 1'b0, 3'd0, 1'b1, AUTO ? 3'd3 : 3'd0, AUTO, 1'b0);
      do_reset("rst_a");

      // Load 7 with en alternating: only enabled edges decrement.
      step("ld7", 1'b1, 3'd7, 1'b0, 3'd7, 1'b1, 1'b0);
      begin
         int enabled = 0;
         for (int i = 0; i < 14; i++) begin
            logic e;
            e = (i % 2 == 0);
            if (e) enabled++;
            step("ld7_cnt", 1'b0, 3'd0, e, 3'(7 - enabled), enabled < 7, enabled == 7 && e);
            if (enabled == 7) break;
         end
      end

      // Load 0 from DONE: straight to DONE, never busy, then idle (reload is 0).
      step("ld0",       1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
      step("ld0_after", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
      step("ld0_idle",  1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);

      // Load wins over the terminal decrement at Q=1.
      step("ld2",      1'b1, 3'd2, 1'b0, 3'd2, 1'b1, 1'b0);
      step("ld2_1",    1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
      step("ld6_term", 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 1'b0);
      step("ld6_hold", 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);

      // Asynchronous reset mid-count at Q=5, no done afterwards.
      step("ld5", 1'b1, 3'd5, 1'b0, 3'd5, 1'b1, 1'b0);
      load = 1'b0; en = 1'b1;
      do_reset("rst_mid_run");
      step("post_rst_a", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
      step("post_rst_b", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);

      // Load during DONE restarts the count.
      step("ld1",      1'b1, 3'd1, 1'b0, 3'd1, 1'b1, 1'b0);
      step("ld1_0",    1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
      step("ld4_done", 1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 1'b0);
      step("ld4_3",    1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0);
      step("ld4_2",    1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0);
      step("ld4_1",    1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
      step("ld4_0",    1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
      step("ld4_after", 1'b0, 3'd0, 1'b1, AUTO ? 3'd4 : 3'd0, AUTO, 1'b0);
      do_reset("rst_b");

      // Reset asserted while in DONE aborts the pulse.
      step("ld1b",   1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b0);
      step("ld1b_0", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
      do_reset("rst_in_done");
      step("post_done_rst", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);

`ifdef AUTO_RELOAD_EN
      // Continuous reload: 2,1,0 repeating with done every third cycle.
      step("ar_ld2", 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b0);
      for (int r = 0; r < 2; r++) begin
         step("ar_1", 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
         step("ar_0", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
         step("ar_2", 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0);
      end
      step("ar_1b", 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
      step("ar_0b", 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
      step("ar_override", 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
